// File: rtl/mux_rr_stream_pkg.sv
// Shared definitions for the registered round-robin stream multiplexer.
package mux_rr_stream_pkg;

   localparam int MODE_FIXED = 0;  // lowest requesting index wins
   localparam int MODE_RR    = 1;  // rotating priority starting at the pointer

   // Width of a channel index; a single channel still gets a 1-bit select.
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mux_rr_stream_rr_arbiter.sv
// N-way arbiter: fixed priority or round-robin with an internal pointer.
module mux_rr_stream_rr_arbiter
   import mux_rr_stream_pkg::*;
#(
   parameter int N    = 2,
   parameter int MODE = MODE_RR,
   localparam int SW  = clog2_min1(N)
) (
   input  logic          Clk,
   input  logic          Clrn,
   input  logic [N-1:0]  req,
   input  logic          adv,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] gnt_idx
);

   logic [SW-1:0] ptr;
   logic          found;
   int            start;

   // Grant search: indices at or above the start point first, then wrap to 0.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      start   = (MODE == MODE_RR) ? int'(ptr) : 0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i >= start)) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = SW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i < start)) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = SW'(i);
         end
      end
   end

   // Pointer moves just past the winner on each accepted transfer; held at 0 in fixed mode.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         ptr <= '0;
      end else if ((MODE == MODE_RR) && adv) begin
         ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mux_rr_stream.sv
// N-input registered stream mux: arbiter, data select and a one-entry output stage.
module mux_rr_stream
   import mux_rr_stream_pkg::*;
#(
   parameter int N    = 2,
   parameter int W    = 5,
   parameter int MODE = MODE_RR,
   localparam int SW  = clog2_min1(N)
) (
   input  logic            Clk,
   input  logic            Clrn,
   input  logic [N-1:0]    In_valid,
   output logic [N-1:0]    In_ready,
   input  logic [N*W-1:0]  In_data,
   output logic            Out_valid,
   input  logic            Out_ready,
   output logic [W-1:0]    Out_data,
   output logic [SW-1:0]   Out_sel
);

   logic [N-1:0]  gnt;
   logic [SW-1:0] gnt_idx;
   logic          load_en;
   logic          adv;
   logic [W-1:0]  sel_data;

   logic          vld_p0;
   logic [W-1:0]  data_p0;
   logic [SW-1:0] sel_p0;

   // The output stage can take a new item when empty or draining this cycle.
   assign load_en  = !vld_p0 || Out_ready;
   // Clrn gating keeps every channel unacknowledged while reset is held.
   assign In_ready = gnt & {N{load_en & Clrn}};
   assign adv      = |In_ready;

   mux_rr_stream_rr_arbiter #(
      .N    (N),
      .MODE (MODE)
   ) u_arb (
      .Clk     (Clk),
      .Clrn    (Clrn),
      .req     (In_valid),
      .adv     (adv),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Pick the winning channel's data word.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SW'(i)) sel_data = In_data[i*W +: W];
      end
   end

   // ---- stage p0: output register (load overrides drain on the same edge) ----
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         sel_p0  <= '0;
      end else if (adv) begin
         vld_p0  <= 1'b1;
         data_p0 <= sel_data;
         sel_p0  <= gnt_idx;
      end else if (Out_ready) begin
         vld_p0  <= 1'b0;
      end
   end

   assign Out_valid = vld_p0;
   assign Out_data  = data_p0;
   assign Out_sel   = sel_p0;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Scoreboard bench for mux_rr_stream across several N/MODE configurations.
module tb_mux_rr_stream;

   logic clk;
   logic clrn;

   // DUT A: N=2 round-robin
   logic [1:0]  va, ra;
   logic [9:0]  da;
   logic        ova, orda;
   logic [4:0]  oda;
   logic [0:0]  osa;
   // DUT B: N=4 round-robin
   logic [3:0]  vb, rb;
   logic [19:0] db;
   logic        ovb, ordb;
   logic [4:0]  odb;
   logic [1:0]  osb;
   // DUT C: N=4 fixed priority
   logic [3:0]  vc, rc;
   logic [19:0] dc;
   logic        ovc, ordc;
   logic [4:0]  odc;
   logic [1:0]  osc;
   // DUT D: N=3 round-robin
   logic [2:0]  vd, rd;
   logic [14:0] dd;
   logic        ovd, ordd;
   logic [4:0]  odd;
   logic [1:0]  osd;
   // DUT E: N=1 register slice
   logic [0:0]  ve, re;
   logic [4:0]  de;
   logic        ove, orde;
   logic [4:0]  ode;
   logic [0:0]  ose;

   int checks = 0;
   int errors = 0;

   // Expected items as {sel[1:0], data[4:0]}, one queue per DUT.
   logic [6:0] q0[$];
   logic [6:0] q1[$];
   logic [6:0] q2[$];
   logic [6:0] q3[$];
   logic [6:0] q4[$];

   logic       mv[5];
   logic [6:0] md[5];

   mux_rr_stream #(.N(2), .W(5), .MODE(1)) u_a (
      .Clk(clk), .Clrn(clrn), .In_valid(va), .In_ready(ra), .In_data(da),
      .Out_valid(ova), .Out_ready(orda), .Out_data(oda), .Out_sel(osa));
   mux_rr_stream #(.N(4), .W(5), .MODE(1)) u_b (
      .Clk(clk), .Clrn(clrn), .In_valid(vb), .In_ready(rb), .In_data(db),
      .Out_valid(ovb), .Out_ready(ordb), .Out_data(odb), .Out_sel(osb));
   mux_rr_stream #(.N(4), .W(5), .MODE(0)) u_c (
      .Clk(clk), .Clrn(clrn), .In_valid(vc), .In_ready(rc), .In_data(dc),
      .Out_valid(ovc), .Out_ready(ordc), .Out_data(odc), .Out_sel(osc));
   mux_rr_stream #(.N(3), .W(5), .MODE(1)) u_d (
      .Clk(clk), .Clrn(clrn), .In_valid(vd), .In_ready(rd), .In_data(dd),
      .Out_valid(ovd), .Out_ready(ordd), .Out_data(odd), .Out_sel(osd));
   mux_rr_stream #(.N(1), .W(5), .MODE(1)) u_e (
      .Clk(clk), .Clrn(clrn), .In_valid(ve), .In_ready(re), .In_data(de),
      .Out_valid(ove), .Out_ready(orde), .Out_data(ode), .Out_sel(ose));

   assign mv[0] = ova & orda;
   assign mv[1] = ovb & ordb;
   assign mv[2] = ovc & ordc;
   assign mv[3] = ovd & ordd;
   assign mv[4] = ove & orde;
   assign md[0] = {1'b0, osa, oda};
   assign md[1] = {osb, odb};
   assign md[2] = {osc, odc};
   assign md[3] = {osd, odd};
   assign md[4] = {1'b0, ose, ode};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every consumed output item is popped from its DUT's queue and compared.
   always @(negedge clk) begin
      logic [6:0] e;
      bit         have;
      for (int d = 0; d < 5; d++) begin
         if (mv[d]) begin
            have = 1'b0;
            e    = '0;
            case (d)
               0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
               1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
               2: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
               3: if (q3.size() > 0) begin have = 1'b1; e = q3.pop_front(); end
               default: if (q4.size() > 0) begin have = 1'b1; e = q4.pop_front(); end
            endcase
            checks++;
            if (!have) begin
               errors++;
               $display("FAIL out_unexpected dut%0d got sel=%0d data=%h required no item",
                        d, md[d][6:5], md[d][4:0]);
            end else if (md[d] !== e) begin
               errors++;
               $display("FAIL out_item dut%0d got sel=%0d data=%h required sel=%0d data=%h",
                        d, md[d][6:5], md[d][4:0], e[6:5], e[4:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clrn = 1'b0;
      va = '0; da = '0; orda = 1'b0;
      vb = '0; db = '0; ordb = 1'b0;
      vc = '0; dc = '0; ordc = 1'b0;
      vd = '0; dd = '0; ordd = 1'b0;
      ve = '0; de = '0; orde = 1'b0;

      // Reset state, with requests present
      va = 2'b11; ve = 1'b1;
      #3;
      chk("rst_in_ready_a", ra, 0);
      chk("rst_in_ready_e", re, 0);
      chk("rst_out_valid_a", ova, 0);
      chk("rst_out_data_a", oda, 0);
      chk("rst_out_sel_a", osa, 0);
      chk("rst_out_valid_b", ovb, 0);
      step(); step();
      clrn = 1'b1; va = '0; ve = '0;

      // Mid-stream asynchronous reset
      va = 2'b01; da = {5'h00, 5'h1A}; orda = 1'b0;
      #1 chk("load_ready_a", ra, 2'b01);
      step();
      va = '0;
      chk("loaded_valid_a", ova, 1);
      chk("loaded_data_a", oda, 5'h1A);
      #2 clrn = 1'b0;
      #1;
      chk("async_rst_valid_a", ova, 0);
      chk("async_rst_data_a", oda, 0);
      step();
      clrn = 1'b1;
      va = 2'b11; da = {5'h05, 5'h04}; orda = 1'b1;
      #1 chk("rr_first_after_reset", ra, 2'b01);
      q0.push_back({2'd0, 5'h04});

      // Single channel request on channel 1
      step();
      va = 2'b10; da = {5'h13, 5'h00};
      #1 chk("single_ch1_ready", ra, 2'b10);
      q0.push_back({2'd1, 5'h13});
      step();
      chk("single_valid", ova, 1);
      chk("single_data", oda, 5'h13);
      chk("single_sel", osa, 1);

      // Backpressure: load 07, then stall three cycles with both channels requesting
      va = 2'b01; da = {5'h00, 5'h07};
      #1 chk("bp_load_ready", ra, 2'b01);
      q0.push_back({2'd0, 5'h07});
      step();
      orda = 1'b0; va = 2'b11; da = {5'h0B, 5'h0A};
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", ra, 0);
         chk("bp_data_frozen", oda, 5'h07);
         chk("bp_sel_frozen", osa, 0);
         chk("bp_valid_held", ova, 1);
         step();
      end
      orda = 1'b1;
      #1 chk("bp_ptr_held", ra, 2'b10);
      q0.push_back({2'd1, 5'h0B});
      step();
      va = 2'b01;
      #1 chk("bp_reload_ready", ra, 2'b01);
      q0.push_back({2'd0, 5'h0A});
      step();
      va = 2'b00;
      #1 chk("idle_ready", ra, 0);
      step();
      chk("drain_valid", ova, 0);
      chk("drain_data_hold", oda, 5'h0A);
      chk("drain_sel_hold", osa, 0);

      // Round-robin fairness, N=4
      vb = 4'hF; db = {5'h13, 5'h12, 5'h11, 5'h10}; ordb = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr4_ready", rb, 32'(1) << (k % 4));
         if (k > 0) chk("rr4_valid_cont", ovb, 1);
         q1.push_back({2'(k % 4), 5'(5'h10 + (k % 4))});
         step();
      end
      vb = '0;
      step(); step();

      // Fixed priority, N=4
      vc = 4'b1010; dc = {5'h1B, 5'h1A, 5'h19, 5'h18}; ordc = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 chk("fixed_ready", rc, 4'b0010);
         q2.push_back({2'd1, 5'h19});
         step();
      end
      vc = 4'b1000;
      #1 chk("fixed_ch3_alone", rc, 4'b1000);
      q2.push_back({2'd3, 5'h1B});
      step();
      vc = '0;
      step(); step();

      // Pointer wrap, N=3
      vd = 3'b010; dd = {5'h0E, 5'h0D, 5'h0C}; ordd = 1'b1;
      #1 chk("wrap_set_ptr", rd, 3'b010);
      q3.push_back({2'd1, 5'h0D});
      step();
      vd = 3'b101;
      #1 chk("wrap_grant2", rd, 3'b100);
      q3.push_back({2'd2, 5'h0E});
      step();
      #1 chk("wrap_grant0", rd, 3'b001);
      q3.push_back({2'd0, 5'h0C});
      step();
      vd = '0;
      step(); step();

      // N=1 register slice with a stall
      ve = 1'b1; de = 5'h15; orde = 1'b0;
      #1 chk("n1_ready", re, 1);
      q4.push_back({2'd0, 5'h15});
      step();
      de = 5'h16;
      #1;
      chk("n1_stall_ready", re, 0);
      chk("n1_valid", ove, 1);
      step();
      chk("n1_data_frozen", ode, 5'h15);
      orde = 1'b1;
      #1 chk("n1_reload_ready", re, 1);
      q4.push_back({2'd0, 5'h16});
      step();
      ve = '0;
      step(); step();

      // Every expected item must have been delivered
      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      chk("q2_empty", q2.size(), 0);
      chk("q3_empty", q3.size(), 0);
      chk("q4_empty", q4.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
